// File: rtl/latch_7475_pkg.sv
// Shared definitions for the 7475 latch loader: FSM state encoding,
// pair-select bit positions and default phase timing.
package latch_7475_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Bit positions inside req_sel
  localparam int SEL_12 = 0;
  localparam int SEL_34 = 1;

  // Default phase lengths in clock cycles
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;
  localparam int DEF_CNT_W     = 4;

  // A phase of N cycles is timed by loading N-1 and running down to zero
  function automatic int phase_load(input int cyc);
    return cyc - 32'sd1;
  endfunction

endpackage

// File: rtl/latch_7475_loader_counter.sv
// phase_down_counter: loadable down counter used to time FSM phases.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val this cycle (wins over dec)
//   load_val    value to load
//   dec         decrement while non-zero
//   cnt_zero    count is zero
module phase_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             cnt_zero
);

  logic [CNT_W-1:0] cnt_r;

  assign cnt_zero = (cnt_r == {CNT_W{1'b0}});

  // Count register: load has priority, otherwise saturating decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && !cnt_zero) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/latch_7475_loader.sv
// latch_7475_loader: write-side controller for a 7475-style quad latch.
// Accepts a 4-bit word and pair select over valid/ready, drives the data
// lines, strobes the selected enable(s) with setup/pulse/hold spacing and
// pulses done on return to IDLE.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_data[3:0]          bit0->d1 .. bit3->d4
//   req_sel[1:0]           bit0 strobes c12, bit1 strobes c34
//   busy, done             operation in progress / one-cycle completion
//   d1..d4, c12, c34       registered latch data and enables
module latch_7475_loader
  import latch_7475_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_data,
  input  logic [1:0] req_sel,
  output logic       busy,
  output logic       done,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4,
  output logic       c12,
  output logic       c34
);

  state_e           state_r;
  state_e           next_state_s;
  logic [1:0]       sel_r;
  logic [3:0]       d_r;
  logic             c12_r;
  logic             c34_r;
  logic             done_r;
  logic             busy_r;
  logic             accept_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             cnt_zero_s;

  // Ready is withheld while reset is asserted so no output reads 1 in reset
  assign req_ready = reset_n && (state_r == IDLE);
  assign accept_s  = req_valid && req_ready;

  assign d1   = d_r[0];
  assign d2   = d_r[1];
  assign d3   = d_r[2];
  assign d4   = d_r[3];
  assign c12  = c12_r;
  assign c34  = c34_r;
  assign done = done_r;
  assign busy = busy_r;

  phase_down_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (1'b1),
    .cnt_zero (cnt_zero_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an empty select completes without leaving IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (req_sel != 2'b00)) begin
          next_state_s = SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_zero_s) next_state_s = PULSE;
        else            next_state_s = SETUP;
      end
      PULSE: begin
        if (cnt_zero_s) next_state_s = HOLD;
        else            next_state_s = PULSE;
      end
      HOLD: begin
        if (cnt_zero_s) next_state_s = IDLE;
        else            next_state_s = HOLD;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Phase counter reload on every state change with the new phase length
  always_comb begin
    cnt_load_s     = (next_state_s != state_r);
    cnt_load_val_s = {CNT_W{1'b0}};
    case (next_state_s)
      SETUP:   cnt_load_val_s = CNT_W'(phase_load(SETUP_CYC));
      PULSE:   cnt_load_val_s = CNT_W'(phase_load(PULSE_CYC));
      HOLD:    cnt_load_val_s = CNT_W'(phase_load(HOLD_CYC));
      default: cnt_load_val_s = {CNT_W{1'b0}};
    endcase
  end

  // Output and capture registers. Data only moves on accept, while both
  // enables are low, so the latch never sees data change under an enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_r    <= 4'b0000;
      sel_r  <= 2'b00;
      c12_r  <= 1'b0;
      c34_r  <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      if (accept_s && (req_sel != 2'b00)) begin
        d_r   <= req_data;
        sel_r <= req_sel;
      end else begin
        d_r   <= d_r;
        sel_r <= sel_r;
      end
      c12_r  <= (next_state_s == PULSE) && sel_r[SEL_12];
      c34_r  <= (next_state_s == PULSE) && sel_r[SEL_34];
      done_r <= ((state_r == HOLD) && cnt_zero_s) ||
                (accept_s && (req_sel == 2'b00));
      busy_r <= (next_state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_latch_7475_loader.sv
// Directed bench for latch_7475_loader with a behavioural 7475 latch on
// the outputs. Inputs change and outputs are sampled on the falling edge.
module tb_latch_7475_loader;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_data;
  logic [1:0] req_sel;
  logic       busy, done, d1, d2, d3, d4, c12, c34;
  logic       q1, q2, q3, q4;
  logic [7:0] vec;
  logic [7:0] qv;
  int         total_cnt;
  int         pass_cnt;

  latch_7475_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_sel   (req_sel),
    .busy      (busy),
    .done      (done),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .c12       (c12),
    .c34       (c34)
  );

  // Behavioural 7475: transparent while enable is high
  always_latch begin
    if (c12) begin
      q1 <= d1;
      q2 <= d2;
    end
  end

  always_latch begin
    if (c34) begin
      q3 <= d3;
      q4 <= d4;
    end
  end

  assign vec = {done, busy, c12, c34, d4, d3, d2, d1};
  assign qv  = {4'b0000, q4, q3, q2, q1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one request; returns at the falling edge of cycle 1
  task automatic send(input logic [3:0] data, input logic [1:0] sel);
    req_valid = 1'b1;
    req_data  = data;
    req_sel   = sel;
    chk("ready_before_accept", {7'b0, req_ready}, 8'h01);
    tick();
    req_valid = 1'b0;
  endtask

  // Full operation with expected outputs built from data/sel
  task automatic op(input string tag, input logic [3:0] data, input logic [1:0] sel);
    send(data, sel);
    chk({tag, "_setup"}, vec, {2'b01, 2'b00, data});
    tick();
    chk({tag, "_pulse1"}, vec, {2'b01, sel[0], sel[1], data});
    tick();
    chk({tag, "_pulse2"}, vec, {2'b01, sel[0], sel[1], data});
    tick();
    chk({tag, "_hold"}, vec, {2'b01, 2'b00, data});
    tick();
    chk({tag, "_done"}, vec, {2'b10, 2'b00, data});
    chk({tag, "_ready_in_done"}, {7'b0, req_ready}, 8'h01);
    tick();
    chk({tag, "_idle"}, vec, {2'b00, 2'b00, data});
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_data  = 4'b0000;
    req_sel   = 2'b00;

    // Reset state
    #2;
    chk("reset_outputs", vec, 8'h00);
    chk("reset_ready", {7'b0, req_ready}, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_ready", {7'b0, req_ready}, 8'h01);
    chk("post_reset_outputs", vec, 8'h00);

    // Load all four latches so later partial writes are observable
    op("init", 4'b1111, 2'b11);
    chk("init_q", qv, 8'b0000_1111);

    // Pair 1-2 only: q1=0, q2=1, q3/q4 keep 1
    op("sel01", 4'b1010, 2'b01);
    chk("sel01_q", qv, 8'b0000_1110);

    // Both pairs together
    op("sel11", 4'b0110, 2'b11);
    chk("sel11_q", qv, 8'b0000_0110);

    // Empty select: done next cycle, data lines untouched
    send(4'b1111, 2'b00);
    chk("sel00_done", vec, {2'b10, 2'b00, 4'b0110});
    tick();
    chk("sel00_idle", vec, {2'b00, 2'b00, 4'b0110});
    chk("sel00_q", qv, 8'b0000_0110);

    // Back-to-back with junk on req_* while busy
    req_valid = 1'b1;
    req_data  = 4'b0001;
    req_sel   = 2'b01;
    tick();
    chk("b2b_a_setup", vec, {2'b01, 2'b00, 4'b0001});
    req_data = 4'b1110; req_sel = 2'b10;
    tick();
    chk("b2b_a_pulse1", vec, {2'b01, 2'b10, 4'b0001});
    req_data = 4'b0110;
    tick();
    chk("b2b_a_pulse2", vec, {2'b01, 2'b10, 4'b0001});
    req_data = 4'b1110;
    tick();
    chk("b2b_a_hold", vec, {2'b01, 2'b00, 4'b0001});
    req_data = 4'b0110;
    tick();
    chk("b2b_a_done", vec, {2'b10, 2'b00, 4'b0001});
    chk("b2b_a_ready", {7'b0, req_ready}, 8'h01);
    chk("b2b_a_q", qv, 8'b0000_0101);
    req_data = 4'b1000;
    req_sel  = 2'b10;
    tick();
    chk("b2b_b_setup", vec, {2'b01, 2'b00, 4'b1000});
    req_valid = 1'b0;
    tick();
    chk("b2b_b_pulse1", vec, {2'b01, 2'b01, 4'b1000});
    tick();
    chk("b2b_b_pulse2", vec, {2'b01, 2'b01, 4'b1000});
    tick();
    chk("b2b_b_hold", vec, {2'b01, 2'b00, 4'b1000});
    tick();
    chk("b2b_b_done", vec, {2'b10, 2'b00, 4'b1000});
    chk("b2b_b_q", qv, 8'b0000_1001);
    tick();

    // Reset in the middle of PULSE
    send(4'b1111, 2'b01);
    tick();
    chk("rst_mid_pulse", vec, {2'b01, 2'b10, 4'b1111});
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", vec, 8'h00);
    chk("rst_async_ready", {7'b0, req_ready}, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_after_release", vec, 8'h00);
    chk("rst_ready_after", {7'b0, req_ready}, 8'h01);
    tick();
    chk("rst_no_done", vec, 8'h00);

    // Normal operation after the aborted one
    op("recover", 4'b0011, 2'b11);
    chk("recover_q", qv, 8'b0000_0011);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
